var_shift_engine: RTL



---
 rtl/var_shift_pkg.sv | 23 ++
 rtl/var_shift_if.sv | 44 ++++
 rtl/var_shift_step.sv | 42 ++++
 rtl/var_shift_engine.sv | 118 +++++++++++
 4 files changed

// File: rtl/var_shift_pkg.sv
// var_shift_pkg: shared types and constants for the variable shift engine.
//   mode_t  : shift mode encoding (fill-in, logical, arithmetic, rotate)
//   state_t : control FSM states (IDLE, SHIFT, DONE)
//   DIR_*   : direction encoding of the dir input
package var_shift_pkg;

    typedef enum logic [1:0] {
        MODE_FILL  = 2'b00,
        MODE_LOG   = 2'b01,
        MODE_ARITH = 2'b10,
        MODE_ROT   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/var_shift_if.sv
// var_shift_if: request/result bundle of the variable shift engine.
//   ld, ld_data                 : direct load of q (honoured in IDLE only)
//   start_valid, start_ready    : operation handshake
//   dir, mode, shift, din       : operation parameters, captured on accept
//   q, busy, done               : register contents and status
//   sticky                      : OR of shifted-out bits (only with VAR_SHIFT_STICKY_EN)
// master drives requests (client side), slave is the engine.
interface var_shift_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH) + 1
);
    logic             ld;
    logic [WIDTH-1:0] ld_data;
    logic             start_valid;
    logic             start_ready;
    logic             dir;
    logic [1:0]       mode;
    logic [SHW-1:0]   shift;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
`ifdef VAR_SHIFT_STICKY_EN
    logic             sticky;

    modport master (
        output ld, ld_data, start_valid, dir, mode, shift, din,
        input  start_ready, q, busy, done, sticky
    );
    modport slave (
        input  ld, ld_data, start_valid, dir, mode, shift, din,
        output start_ready, q, busy, done, sticky
    );
`else
    modport master (
        output ld, ld_data, start_valid, dir, mode, shift, din,
        input  start_ready, q, busy, done
    );
    modport slave (
        input  ld, ld_data, start_valid, dir, mode, shift, din,
        output start_ready, q, busy, done
    );
`endif
endinterface

// File: rtl/var_shift_step.sv
// var_shift_step: combinational single-chunk shifter (k <= STEP bits).
//   q, fill   : current register and fill register
//   k         : bits to shift this chunk
//   dir, mode : operation captured at accept
//   sign      : q MSB sampled at accept (arithmetic right fill)
//   q_nxt     : register after this chunk
//   fill_nxt  : fill register with the consumed bits removed
//   out_or    : OR of the bits of q shifted out by this chunk
module var_shift_step
    import var_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 8,
    parameter int KW    = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] fill,
    input  logic [KW-1:0]    k,
    input  logic             dir,
    input  mode_t            mode,
    input  logic             sign,
    output logic [WIDTH-1:0] q_nxt,
    output logic [WIDTH-1:0] fill_nxt,
    output logic             out_or
);

    logic [WIDTH-1:0] word;

    // word is the source of incoming bits: concatenated beside q, a plain
    // double-width shift then covers fill-in, zero/sign fill and rotate alike.
    always_comb begin
        word     = mode == MODE_FILL ? fill :
                   mode == MODE_ROT ? q :
                   (mode == MODE_ARITH && dir == DIR_RIGHT) ? {WIDTH{sign}} : '0;
        q_nxt    = dir == DIR_LEFT ? WIDTH'(({q, word} << k) >> WIDTH)
                                   : WIDTH'({word, q} >> k);
        fill_nxt = dir == DIR_LEFT ? fill << k : fill >> k;
        out_or   = dir == DIR_LEFT ? |(q & ~({WIDTH{1'b1}} >> k))
                                   : |(q & ~({WIDTH{1'b1}} << k));
    end

endmodule

// File: rtl/var_shift_engine.sv
// var_shift_engine: WIDTH-bit register with direct load and multi-cycle
// variable shift (fill-in / logical / arithmetic / rotate), STEP bits per cycle.
//   clk : clock, rising edge
//   clr : asynchronous active-low clear
//   en  : global enable, 0 freezes all state
//   bus : var_shift_if slave (load, start handshake, operands, q/busy/done)
// Optional: define VAR_SHIFT_STICKY_EN to add bus.sticky, the OR of all bits
// shifted out of q during the last operation (always 0 for rotate and S=0).
module var_shift_engine
    import var_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input logic      clk,
    input logic      clr,
    input logic      en,
    var_shift_if.slave bus
);

    localparam int KW = $clog2(STEP) + 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q, fill, q_step, fill_step;
    logic [SHW-1:0]   remaining, s_amt;
    logic [KW-1:0]    k;
    logic             dir_r, sign_r, out_or, accept;
    mode_t            mode_r;

    assign bus.start_ready = en && state == IDLE && !bus.ld;
    assign bus.busy        = state != IDLE;
    assign bus.done        = state == DONE;
    assign bus.q           = q;
    assign accept          = bus.start_valid && bus.start_ready;

    // Rotate wraps modulo WIDTH; every other mode saturates at WIDTH.
    assign s_amt = mode_t'(bus.mode) == MODE_ROT ? {1'b0, bus.shift[SHW-2:0]} :
                   bus.shift > SHW'(WIDTH) ? SHW'(WIDTH) : bus.shift;
    assign k     = remaining > SHW'(STEP) ? KW'(STEP) : KW'(remaining);

    var_shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .q        (q),
        .fill     (fill),
        .k        (k),
        .dir      (dir_r),
        .mode     (mode_r),
        .sign     (sign_r),
        .q_nxt    (q_step),
        .fill_nxt (fill_step),
        .out_or   (out_or)
    );

    always_comb begin
        state_nxt = state;
        if (en) begin
            case (state)
                IDLE:    state_nxt = accept ? (s_amt == '0 ? DONE : SHIFT) : IDLE;
                SHIFT:   state_nxt = remaining == SHW'(k) ? DONE : SHIFT;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            q         <= '0;
            fill      <= '0;
            remaining <= '0;
            dir_r     <= DIR_RIGHT;
            mode_r    <= MODE_FILL;
            sign_r    <= 1'b0;
        end else if (en) begin
            state <= state_nxt;
            if (state == IDLE && bus.ld) begin
                q <= bus.ld_data;
            end else if (accept) begin
                dir_r     <= bus.dir;
                mode_r    <= mode_t'(bus.mode);
                fill      <= bus.din;
                sign_r    <= q[WIDTH-1];
                remaining <= s_amt;
            end else if (state == SHIFT) begin
                q         <= q_step;
                fill      <= fill_step;
                remaining <= remaining - SHW'(k);
            end
        end
    end

`ifdef VAR_SHIFT_STICKY_EN
    logic sticky;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sticky <= 1'b0;
        end else if (en) begin
            if (accept) begin
                sticky <= 1'b0;
            end else if (state == SHIFT && mode_r != MODE_ROT) begin
                sticky <= sticky | out_or;
            end
        end
    end

    assign bus.sticky = sticky;
`else
    logic unused_out_or;
    assign unused_out_or = out_or;
`endif

endmodule
